// File: rtl/elevator_pkg.sv
// Shared types and default configuration for the elevator SCAN controller.
//   state_e : controller state (IDLE, MOVE, DOOR)
//   dir_e   : travel direction register encoding (UP, DOWN)
//   DEF_*   : default parameter values used by elevator_scan_ctrl
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

  localparam int unsigned DEF_NUM_FLOORS  = 4;
  localparam int unsigned DEF_MOVE_CYCLES = 4;
  localparam int unsigned DEF_DOOR_CYCLES = 8;

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational call scanner: reports outstanding calls relative to a floor.
// Ports:
//   pending   in  NUM_FLOORS  call vector to scan
//   cur_floor in  FLOOR_W     reference floor
//   any_above out 1           a call exists strictly above cur_floor
//   any_below out 1           a call exists strictly below cur_floor
//   here      out 1           a call exists at cur_floor
module elevator_req_scan #(
  parameter int unsigned NUM_FLOORS = 4,
  parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here
);

  // Linear scan; NUM_FLOORS is small so a flat OR-reduce per region is fine.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    here      = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > cur_floor) any_above = any_above | pending[i];
      if (FLOOR_W'(i) < cur_floor) any_below = any_below | pending[i];
      if (FLOOR_W'(i) == cur_floor) here = here | pending[i];
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator controller using SCAN (elevator) ordering.
// Calls are latched in pending; the car keeps its direction while calls
// remain ahead, then reverses to serve calls it has already passed.
// Optional feature: define ELEVATOR_ESTOP_EN to add the estop input, which
// freezes the FSM and its counters while still latching new calls.
// Ports:
//   clk          in   1           clock, rising edge
//   rst          in   1           synchronous active-low reset
//   estop        in   1           emergency stop (ELEVATOR_ESTOP_EN only)
//   req          in   NUM_FLOORS  floor call pulses
//   cur_floor    out  FLOOR_W     current floor
//   floor_onehot out  NUM_FLOORS  one-hot of cur_floor
//   moving_up    out  1           travelling up
//   moving_down  out  1           travelling down
//   door_open    out  1           door open at cur_floor
//   pending      out  NUM_FLOORS  outstanding calls
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int unsigned MOVE_CYCLES = DEF_MOVE_CYCLES,
  parameter int unsigned DOOR_CYCLES = DEF_DOOR_CYCLES,
  parameter int unsigned FLOOR_W     = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] req,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic [NUM_FLOORS-1:0] floor_onehot,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int unsigned MOVE_CW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int unsigned DOOR_CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MOVE_CW-1:0] MOVE_LAST = MOVE_CW'(MOVE_CYCLES - 1);
  localparam logic [DOOR_CW-1:0] DOOR_LAST = DOOR_CW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  state_e                  state_q, state_d;
  dir_e                    dir_q, dir_d;
  logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
  logic [NUM_FLOORS-1:0]   floor_onehot_q, floor_onehot_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [MOVE_CW-1:0]      move_cnt_q, move_cnt_d;
  logic [DOOR_CW-1:0]      door_cnt_q, door_cnt_d;
  logic                    moving_up_q, moving_up_d;
  logic                    moving_down_q, moving_down_d;
  logic                    door_open_q, door_open_d;

  logic [NUM_FLOORS-1:0]   eff;
  logic [NUM_FLOORS-1:0]   floor_clr;
  logic                    any_above, any_below, here;
  logic                    ahead, behind;
  logic [FLOOR_W-1:0]      step_floor;
  logic                    step_hit, step_end, req_here;

  // Calls arriving this cycle take part in decisions immediately.
  assign eff = pending_q | req;

  elevator_req_scan #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_scan (
    .pending   (eff),
    .cur_floor (cur_floor_q),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here)
  );

  // Floor reached at the end of the current one-floor move, clamped to the shaft.
  always_comb begin
    step_floor = cur_floor_q;
    if (dir_q == UP) begin
      if (cur_floor_q != TOP_FLOOR) step_floor = cur_floor_q + FLOOR_W'(1);
    end else begin
      if (cur_floor_q != '0) step_floor = cur_floor_q - FLOOR_W'(1);
    end
    step_end = (dir_q == UP) ? (step_floor == TOP_FLOOR) : (step_floor == '0);
    step_hit = 1'b0;
    req_here = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == step_floor) step_hit = eff[i];
      if (FLOOR_W'(i) == cur_floor_q) req_here = req[i];
    end
    ahead  = (dir_q == UP) ? any_above : any_below;
    behind = (dir_q == UP) ? any_below : any_above;
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cur_floor_d = cur_floor_q;
    move_cnt_d  = '0;
    door_cnt_d  = '0;
    case (state_q)
      IDLE: begin
        if (here) begin
          state_d = DOOR;
        end else if (any_above) begin
          state_d = MOVE;
          dir_d   = UP;
        end else if (any_below) begin
          state_d = MOVE;
          dir_d   = DOWN;
        end
      end
      MOVE: begin
        if (move_cnt_q == MOVE_LAST) begin
          cur_floor_d = step_floor;
          if (step_hit) begin
            state_d = DOOR;
          end else if (step_end) begin
            // Nothing left to reach in this direction; let IDLE re-plan.
            state_d = IDLE;
          end
        end else begin
          move_cnt_d = move_cnt_q + MOVE_CW'(1);
        end
      end
      DOOR: begin
        if (req_here) begin
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          if (ahead) begin
            state_d = MOVE;
          end else if (behind) begin
            state_d = MOVE;
            dir_d   = (dir_q == UP) ? DOWN : UP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          door_cnt_d = door_cnt_q + DOOR_CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ELEVATOR_ESTOP_EN
    // Freeze everything except call latching.
    if (estop) begin
      state_d     = state_q;
      dir_d       = dir_q;
      cur_floor_d = cur_floor_q;
      move_cnt_d  = move_cnt_q;
      door_cnt_d  = door_cnt_q;
    end
`endif
  end

  // Registered output values derived from the next state.
  always_comb begin
    floor_clr = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      floor_onehot_d[i] = (FLOOR_W'(i) == cur_floor_d);
    end
    // The floor whose door is (or stays) open never holds a pending call.
    if (state_d == DOOR) floor_clr = floor_onehot_d;
    pending_d     = eff & ~floor_clr;
    moving_up_d   = (state_d == MOVE) && (dir_d == UP);
    moving_down_d = (state_d == MOVE) && (dir_d == DOWN);
    door_open_d   = (state_d == DOOR);
`ifdef ELEVATOR_ESTOP_EN
    if (estop) begin
      moving_up_d   = 1'b0;
      moving_down_d = 1'b0;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      dir_q          <= UP;
      cur_floor_q    <= '0;
      floor_onehot_q <= NUM_FLOORS'(1);
      pending_q      <= '0;
      move_cnt_q     <= '0;
      door_cnt_q     <= '0;
      moving_up_q    <= 1'b0;
      moving_down_q  <= 1'b0;
      door_open_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      dir_q          <= dir_d;
      cur_floor_q    <= cur_floor_d;
      floor_onehot_q <= floor_onehot_d;
      pending_q      <= pending_d;
      move_cnt_q     <= move_cnt_d;
      door_cnt_q     <= door_cnt_d;
      moving_up_q    <= moving_up_d;
      moving_down_q  <= moving_down_d;
      door_open_q    <= door_open_d;
    end
  end

  assign cur_floor    = cur_floor_q;
  assign floor_onehot = floor_onehot_q;
  assign moving_up    = moving_up_q;
  assign moving_down  = moving_down_q;
  assign door_open    = door_open_q;
  assign pending      = pending_q;

endmodule
